// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Resolves divide-by-zero and signed overflow at accept time; otherwise one quotient bit per cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       div_op,
    input  logic [WIDTH-1:0] left_operand,
    input  logic [WIDTH-1:0] right_operand,
    output logic [WIDTH-1:0] div_res,
    output logic             done,
    output logic             busy,
    output logic             insert_bubble
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? negate(x) : x;
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             sign_q;
    logic             sign_r;
    logic [1:0]       op_q;

    logic             is_signed;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] fix_res;

    // div_op[0] clear selects the signed flavours; div_op[1] set selects remainder
    assign is_signed   = ~div_op[0];
    assign div_zero    = (right_operand == '0);
    assign ovf         = is_signed && (left_operand == MIN_NEG) && (right_operand == ALL_ONES);
    assign special_res = div_zero ? (div_op[1] ? left_operand : ALL_ONES)
                                  : (div_op[1] ? '0 : MIN_NEG);

    // Remainder keeps the bit shifted out of its MSB so large unsigned divisors compare correctly
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvsr};
    assign fix_res   = op_q[1] ? (sign_r ? negate(rem) : rem)
                               : (sign_q ? negate(quo) : quo);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            op_q    <= 2'b00;
            div_res <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= div_op;
                        sign_q <= is_signed & (left_operand[WIDTH-1] ^ right_operand[WIDTH-1]);
                        sign_r <= is_signed & left_operand[WIDTH-1];
                        quo    <= is_signed ? magnitude(left_operand) : left_operand;
                        dvsr   <= is_signed ? magnitude(right_operand) : right_operand;
                        if (div_zero || ovf) begin
                            div_res <= special_res;
                            state   <= DONE;
                        end else begin
                            rem   <= '0;
                            cnt   <= CNT_W'(WIDTH-1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    div_res <= fix_res;
                    state   <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign done          = (state == DONE);
    assign busy          = (state != IDLE);
    assign insert_bubble = ((state == IDLE) && start) || (state == CALC) || (state == FIX);

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: results, latency, stall signalling, busy-start and reset abort.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  div_op;
    logic [31:0] left_operand;
    logic [31:0] right_operand;
    logic [31:0] div_res;
    logic        done;
    logic        busy;
    logic        insert_bubble;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .div_op        (div_op),
        .left_operand  (left_operand),
        .right_operand (right_operand),
        .div_res       (div_res),
        .done          (done),
        .busy          (busy),
        .insert_bubble (insert_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one op, optionally pulses start again at cycle inject_at while busy,
    // and returns at the negedge of the done cycle so the next call can start back-to-back.
    task automatic do_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input int inject_at);
        int n;
        int bubble_gap;
        @(negedge clk);
        start = 1'b1; div_op = op; left_operand = a; right_operand = b;
        #1;
        check_val({tag, " bubble_c0"}, 32'(insert_bubble), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0; div_op = ~op; left_operand = ~a; right_operand = 32'h5;
        n = 0;
        bubble_gap = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (!insert_bubble) bubble_gap++;
            if (inject_at != 0 && n == inject_at) begin
                start = 1'b1; div_op = OP_DIVU; left_operand = 32'd50; right_operand = 32'd5;
            end else if (inject_at != 0 && n == inject_at + 1) begin
                start = 1'b0;
            end
        end
        check_val({tag, " latency"}, 32'(n), 32'(exp_lat));
        check_val({tag, " result"}, div_res, exp_res);
        check_val({tag, " bubble_low_at_done"}, 32'(insert_bubble), 32'd0);
        check_val({tag, " bubble_gaps"}, 32'(bubble_gap), 32'd0);
    endtask

    task automatic check_idle(input string tag, input logic [31:0] exp_res);
        @(negedge clk);
        check_val({tag, " idle_done"}, 32'(done), 32'd0);
        check_val({tag, " idle_busy"}, 32'(busy), 32'd0);
        check_val({tag, " idle_hold"}, div_res, exp_res);
    endtask

    initial begin
        int seen_done;
        rst = 1'b0; start = 1'b0; div_op = 2'b00; left_operand = '0; right_operand = '0;
        repeat (3) @(negedge clk);
        check_val("rst div_res", div_res, 32'h0);
        check_val("rst done", 32'(done), 32'd0);
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst bubble", 32'(insert_bubble), 32'd0);
        rst = 1'b1;

        do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 0);
        check_idle("divu_100_7", 32'd14);
        do_div("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34, 0);
        do_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        do_div("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        do_div("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);
        do_div("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 0);
        do_div("remu_min_max", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);

        do_div("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        check_idle("div_5_0", 32'hFFFF_FFFF);
        do_div("remu_1234_0", OP_REMU, 32'h1234, 32'd0, 32'h1234, 1, 0);
        do_div("rem_m7_0", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 0);

        do_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        do_div("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
        do_div("divu_ovf_ops", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34, 0);

        do_div("busy_start", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 10);
        do_div("b2b_second", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 0);

        // Abort a DIVU 100/7 with reset in cycle 15
        do_div("pre_abort", OP_DIV, 32'd9, 32'd3, 32'd3, 34, 0);
        @(negedge clk);
        start = 1'b1; div_op = OP_DIVU; left_operand = 32'd100; right_operand = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("abort div_res", div_res, 32'h0);
        check_val("abort done", 32'(done), 32'd0);
        check_val("abort busy", 32'(busy), 32'd0);
        check_val("abort bubble", 32'(insert_bubble), 32'd0);
        rst = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        check_val("abort no_done", 32'(seen_done), 32'd0);
        do_div("after_abort", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 0);
        check_idle("after_abort", 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 integer divider implementing RV32M DIV, DIVU, REM and REMU.
- Sits alongside the execute-stage ALU and feeds the ALU result mux for the divide/remainder ops.
- Holds the pipeline through insert_bubble while it iterates, matching how the multiplier stalls the pipeline.
- One quotient bit per cycle; RISC-V special cases resolve early.

Parameters:
WIDTH  32  operand/result width; RISC-V special-case constants are derived from WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets)
start  input  1  request new division; sampled only in IDLE
div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
left_operand  input  WIDTH  dividend
right_operand  input  WIDTH  divisor
div_res  output  WIDTH  quotient or remainder per latched div_op; held until next accepted start
done  output  1  one-cycle pulse, div_res valid this cycle
busy  output  1  high in any state other than IDLE
insert_bubble  output  1  pipeline stall request

Behaviour:
- Reset (rst==0 at an edge):
  - state IDLE.
  - div_res, done, busy, insert_bubble all 0.
  - Counter, remainder, quotient and sign registers cleared.
  - Reset overrides everything, including a division already in progress; no done pulse follows.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge:
  - Latch div_op.
  - Signed ops (DIV, REM): latch absolute values of both operands, plus sign_q = sign(left) XOR sign(right) and sign_r = sign(left).
  - Unsigned ops: latch raw operands, sign flags 0.
  - Divisor==0: load special result, go to DONE. Quotient all ones (0xFFFFFFFF); remainder = dividend unmodified.
  - Signed op with left==0x80000000 and right==0xFFFFFFFF: load special result, go to DONE. Quotient 0x80000000; remainder 0.
  - Otherwise: remainder register = 0, counter = WIDTH-1, go to CALC.
- CALC, one cycle per bit (restoring algorithm):
  - Shift {rem, quo} left by 1.
  - trial = rem_shifted - divisor, computed in WIDTH+1 bits.
  - trial non-negative: rem = trial[WIDTH-1:0] and quo LSB = 1; otherwise keep rem and set quo LSB = 0.
  - Counter decrements; when counter==0 in CALC, go to FIX.
  - Exactly WIDTH CALC cycles.
- FIX (1 cycle):
  - Quotient ops: quotient negated (two's complement) if sign_q.
  - Remainder ops: remainder negated if sign_r.
  - Selected value registered into div_res; go to DONE.
- DONE (1 cycle): done=1, then go to IDLE unconditionally.
- Latency, counting the start edge as cycle 0:
  - Normal: CALC cycles 1..32, FIX cycle 33, done=1 in cycle 34.
  - Special cases: done=1 in cycle 1.
- insert_bubble:
  - Asserted combinationally when (state==IDLE and start) or state is CALC or FIX.
  - Deasserted in DONE so the pipeline advances with div_res.
- Start handling:
  - start while busy (CALC, FIX, DONE) is ignored; latched operands unaffected.
  - Operands and div_op may change freely after the accepting edge.
  - start held high across DONE→IDLE is accepted again in IDLE as a new operation (back-to-back allowed).
- div_res changes only on FIX, special-case load, or reset.

Test Plan:
- DIVU 100/7 → done in cycle 34, div_res=14. REMU 100/7 → div_res=2. insert_bubble high cycles 0–33, low cycle 34.
- DIV -7/2 → 0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). REM 7/-2 → 1. DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF, done in cycle 1. REMU 0x1234/0 → 0x1234. No CALC cycles occur.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0, done in cycle 1. DIVU of the same operands → 0 after the full 34 cycles.
- Start pulsed with new operands in cycle 10 of a busy operation → ignored; the original result is returned in cycle 34. Back-to-back start in the cycle after DONE → second result in its own cycle 34.
- rst=0 in cycle 15 of DIVU 100/7 → next cycle state IDLE, all outputs 0, no done pulse. A fresh start after release completes normally.
